// File: rtl/imem_loader.sv
// imem_loader: streams bytes from a source into instruction memory.
// It packs four bytes per word, least-significant byte first, and writes
// word_count+1 words starting at base_addr. The write address wraps at the
// top of memory.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When it is defined, one
// trailer byte is taken after the last word. That byte is compared with the
// 8-bit sum of all payload bytes, and err is set if the two differ.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3
`ifdef IMEM_LOADER_CHECKSUM_EN
    , CHECK = 3'd4
`endif
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              xfer_s;
  logic [1:0]        byte_cnt_r;
  logic [7:0]        word_cnt_r;
  logic [7:0]        count_r;
  logic [ADDR_W-1:0] addr_r;
  logic [23:0]       word_r;
  logic              in_ready_r;
  logic              mem_wr_en_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_data_r;
  logic              busy_r;
  logic              done_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_r;
  logic              err_r;
`endif

  // A byte moves only when the registered ready and the source valid coincide.
  assign xfer_s = in_valid && in_ready_r;

  // Next-state logic for the load sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = COLLECT;
        else       state_nxt_s = IDLE;
      end
      COLLECT: begin
        if (xfer_s && (byte_cnt_r == 2'd3)) state_nxt_s = WRITE;
        else                                state_nxt_s = COLLECT;
      end
      WRITE: begin
        if (word_cnt_r == count_r) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt_s = CHECK;
`else
          state_nxt_s = DONE;
`endif
        end else begin
          state_nxt_s = COLLECT;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (xfer_s) state_nxt_s = DONE;
        else        state_nxt_s = CHECK;
      end
`endif
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_nxt_s;
  end

  // Outputs are registered from the next state, so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_r  <= 1'b0;
      mem_wr_en_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      in_ready_r  <= (state_nxt_s == COLLECT) || (state_nxt_s == CHECK);
`else
      in_ready_r  <= (state_nxt_s == COLLECT);
`endif
      mem_wr_en_r <= (state_nxt_s == WRITE);
      busy_r      <= (state_nxt_s != IDLE);
      done_r      <= (state_nxt_s == DONE);
    end
  end

  // Datapath: latch the request, assemble bytes, present the word and advance the address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt_r <= 2'd0;
      word_cnt_r <= 8'd0;
      count_r    <= 8'd0;
      addr_r     <= '0;
      word_r     <= 24'd0;
      mem_addr_r <= '0;
      mem_data_r <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_r      <= 8'd0;
      err_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            addr_r     <= base_addr;
            count_r    <= word_count;
            byte_cnt_r <= 2'd0;
            word_cnt_r <= 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_r      <= 8'd0;
            err_r      <= 1'b0;
`endif
          end
        end
        COLLECT: begin
          if (xfer_s) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_r      <= sum_r + in_data;
`endif
            case (byte_cnt_r)
              2'd0: word_r[7:0]   <= in_data;
              2'd1: word_r[15:8]  <= in_data;
              2'd2: word_r[23:16] <= in_data;
              2'd3: begin
                mem_data_r <= {in_data, word_r};
                mem_addr_r <= addr_r;
              end
              default: word_r <= word_r;
            endcase
          end
        end
        WRITE: begin
          addr_r     <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          word_cnt_r <= word_cnt_r + 8'd1;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (xfer_s) err_r <= (in_data != sum_r);
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign mem_wr_en = mem_wr_en_r;
  assign mem_addr  = mem_addr_r;
  assign mem_data  = mem_data_r;
  assign busy      = busy_r;
  assign done      = done_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err       = err_r;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader. The reference model turns each payload
// byte list into the expected list of (address, word) writes using plain
// arithmetic. A separate monitor process compares every write and every done
// pulse against those lists.
module tb_imem_loader;
  logic        clock = 1'b0;
  logic        reset_n, start, in_valid, in_ready, mem_wr_en, busy, done, err;
  logic [7:0]  base_addr, word_count, in_data, mem_addr;
  logic [31:0] mem_data;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        wr_q[$];
  logic       done_q[$];
  logic [7:0] pay_q[$];
  wr_t        w;
  bit         cont_mode = 1'b0;
  bit         have_prev = 1'b0;
  longint     prev_wr = 0;
  bit         prev_we = 1'b0;
  bit         prev_done = 1'b0;
  logic       last_err = 1'b0;
  int         force_trailer = -1;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  imem_loader dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares writes and done pulses against the scoreboard queues
  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_wr_en) begin
        check("wr_busy", busy, 1);
        check("wr_strobe_single", prev_we, 0);
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, expected no write", mem_addr, mem_data);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", mem_addr, w.addr);
          check("wr_data", mem_data, w.data);
        end
        if (cont_mode && have_prev) check("wr_gap_cycles", cyc - prev_wr, 5);
        have_prev = 1'b1;
        prev_wr = cyc;
      end
      if (done) begin
        check("done_busy", busy, 1);
        check("done_single_pulse", prev_done, 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("done_after_last_write", cyc - prev_wr, 1);
`endif
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          check("err_at_done", err, done_q.pop_front());
        end
      end
      prev_we = mem_wr_en;
      prev_done = done;
    end else begin
      prev_we = 1'b0;
      prev_done = 1'b0;
    end
  end

  // Load pay_q starting at base. mode: 0 continuous, 1 toggling, 2 random valid.
  task automatic load(input logic [7:0] base, input logic [7:0] cnt, input int mode,
                      input bit inject_start, input bit start_in_done);
    logic [7:0] stream[$];
    logic [7:0] sum;
    logic       exp_err;
    logic       v;
    int         idx, k, t, nwords;
    sum = 8'd0;
    exp_err = 1'b0;
    nwords = int'(cnt) + 1;
    for (int i = 0; i < nwords; i++) begin
      wr_q.push_back('{addr: 8'(int'(base) + i),
                       data: {pay_q[4*i+3], pay_q[4*i+2], pay_q[4*i+1], pay_q[4*i]}});
    end
    for (int i = 0; i < 4 * nwords; i++) begin
      stream.push_back(pay_q[i]);
      sum = sum + pay_q[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    begin
      logic [7:0] trailer;
      if (force_trailer >= 0)              trailer = 8'(force_trailer);
      else if ($urandom_range(0, 1) == 0)  trailer = sum;
      else                                 trailer = 8'($urandom);
      exp_err = (trailer != sum);
      stream.push_back(trailer);
    end
`endif
    done_q.push_back(exp_err);
    check("err_held_before_start", err, last_err);
    cont_mode = (mode == 0);
    have_prev = 1'b0;
    @(negedge clock);
    start = 1'b1; base_addr = base; word_count = cnt; in_valid = 1'b0;
    idx = 0; k = 0;
    while (idx < stream.size() && k < 5000) begin
      @(negedge clock);
      k++;
      start = 1'b0;
      base_addr = 8'($urandom);
      word_count = 8'($urandom);
      if (inject_start && k == 6) start = 1'b1;
      check("busy_during_load", busy, 1);
      if (k == 1) check("err_cleared_on_start", err, 0);
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = k[0];
      else                v = 1'($urandom_range(0, 1));
      in_valid = v;
      in_data = in_ready ? stream[idx] : 8'($urandom);
      if (v && in_ready) idx++;
    end
    if (idx < stream.size()) begin
      checks++; errors++;
      $display("FAIL feed_timeout: got %0d bytes accepted expected %0d", idx, stream.size());
    end
    t = 0;
    do begin
      @(negedge clock);
      in_valid = 1'b0;
      start = 1'b0;
      t++;
    end while (!done && t < 200);
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles");
    end else if (start_in_done) begin
      start = 1'b1;
      base_addr = 8'($urandom);
      @(negedge clock);
      start = 1'b0;
      check("start_in_done_ignored", busy, 0);
    end
    last_err = exp_err;
    pay_q.delete();
  endtask

  task automatic rand_payload(input int nwords);
    pay_q.delete();
    for (int i = 0; i < 4 * nwords; i++) pay_q.push_back(8'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    base_addr = 8'd0; word_count = 8'd0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_wr_en", mem_wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Single word at 0x10
    pay_q = '{8'h78, 8'h56, 8'h34, 8'h12};
    load(8'h10, 8'd0, 0, 1'b0, 1'b0);

    // Three words wrapping past the top of memory
    rand_payload(3);
    load(8'hFE, 8'd2, 0, 1'b0, 1'b0);

    // Toggling valid
    rand_payload(4);
    load(8'h40, 8'd3, 1, 1'b0, 1'b0);

    // Reset after two bytes of a partial word
    @(negedge clock);
    start = 1'b1; base_addr = 8'h20; word_count = 8'd1;
    @(negedge clock);
    start = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
    @(negedge clock);
    in_data = 8'hBB;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_mem_wr_en", mem_wr_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_mem_data", mem_data, 0);
    @(negedge clock);
    reset_n = 1'b1;
    last_err = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data = 8'($urandom);
      check("post_rst_idle_busy", busy, 0);
      check("post_rst_no_write", mem_wr_en, 0);
    end
    in_valid = 1'b0;
    rand_payload(2);
    load(8'h30, 8'd1, 2, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    force_trailer = 8'h0A;
    load(8'h50, 8'd0, 0, 1'b0, 1'b0);
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    force_trailer = 8'h0B;
    load(8'h50, 8'd0, 0, 1'b0, 1'b0);
    repeat (5) @(negedge clock);
    check("err_sticky", err, 1);
    force_trailer = -1;
`endif

    // Start while busy and start during the done cycle are ignored
    rand_payload(3);
    load(8'h60, 8'd2, 2, 1'b1, 1'b1);

    // Randomized loads
    for (int n = 0; n < 6; n++) begin
      int c;
      c = $urandom_range(0, 5);
      rand_payload(c + 1);
      load(8'($urandom), 8'(c), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Full 256-word load with wrap
    rand_payload(256);
    load(8'h80, 8'd255, 0, 1'b0, 1'b0);

    repeat (5) @(negedge clock);
    check("wr_queue_drained", wr_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
